// File: rtl/lrc_hole_fill_pkg.sv
// Shared constants and read-side state encoding
// for the LR-check hole filler.
package lrc_hole_fill_pkg;
  localparam int WIDTH = 16;
  localparam int OCC = WIDTH + 1;
  localparam int MIS = WIDTH;

  typedef enum logic {
    PASS = 1'b0,
    FILL = 1'b1
  } state_t;
endpackage

// File: rtl/lrc_hole_fill_sync_fifo.sv
// Show-ahead synchronous FIFO, power-of-two depth.
module sync_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign empty = (wp == rp);
  assign full = (wp[AW] != rp[AW]) &&
                (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/lrc_hole_fill.sv
// Fills LR-check holes with min of the valid
// neighbours; runs are resolved before replay.
module lrc_hole_fill #(
  parameter int WIDTH = lrc_hole_fill_pkg::WIDTH,
  parameter int MAX_RUN = 64,
  parameter int PIX_DEPTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic [10:0]      img_width,
  input  logic             fill_en,
  input  logic [WIDTH-1:0] invalid_val,
  input  logic             valid_in,
  input  logic [WIDTH+1:0] disp_in,
  output logic [WIDTH+1:0] disp_out,
  output logic             valid_out,
  output logic             row_done,
  output logic             overflow
);
  import lrc_hole_fill_pkg::*;

  localparam int LW = $clog2(MAX_RUN + 1);
  localparam int PW = WIDTH + 3;
  localparam int RW = WIDTH + LW;

  logic [10:0] col;
  logic [WIDTH-1:0] lv;
  logic lv_ok;
  logic [LW-1:0] run_cnt;
  logic [LW-1:0] run_nxt;
  logic acc, bad, col0, eor, lv_ok_e, hit_max;
  logic [WIDTH-1:0] dv;
  logic close;
  logic [LW-1:0] rlen;
  logic [WIDTH-1:0] rfill;
  logic drop, wr;

  logic pix_full, pix_empty, pix_pop;
  logic run_full, run_empty, run_pop;
  logic [PW-1:0] head;
  logic [RW-1:0] run_head;

  state_t state, nstate;
  logic [LW-1:0] cnt;
  logic cnt_ld, out_ld;
  logic [WIDTH+1:0] out_d;
  logic [WIDTH+1:0] dq;
  logic vq, rq;
  logic head_bad;

  assign acc = clken && valid_in;
  assign bad = |disp_in[WIDTH+1:WIDTH];
  assign dv = disp_in[WIDTH-1:0];
  assign col0 = (col == 11'd0);
  assign eor = (col == img_width - 11'd1);
  assign lv_ok_e = lv_ok && !col0;
  assign run_nxt = run_cnt + 1'b1;
  assign hit_max = (run_nxt == LW'(MAX_RUN));

  // A valid pixel closes an open run as its right neighbour
  always_comb begin
    close = 1'b0;
    rlen = run_cnt;
    rfill = invalid_val;
    if (bad) begin
      close = eor || hit_max;
      rlen = run_nxt;
      rfill = lv_ok_e ? lv : invalid_val;
    end else if (run_cnt != '0) begin
      close = 1'b1;
      if (lv_ok_e) rfill = (lv < dv) ? lv : dv;
      else rfill = dv;
    end
  end

  assign drop = acc && (pix_full || (close && run_full));
  assign wr = acc && !drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      lv <= '0;
      lv_ok <= 1'b0;
      run_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (acc) begin
        col <= eor ? 11'd0 : col + 11'd1;
        if (wr && !bad) begin
          lv <= dv;
          lv_ok <= 1'b1;
        end else begin
          lv_ok <= lv_ok_e;
        end
      end
      if (wr) begin
        if (bad) run_cnt <= close ? '0 : run_nxt;
        else run_cnt <= '0;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  sync_fifo #(.DW(PW), .DEPTH(PIX_DEPTH)) u_pix (
    .clk(clk),
    .rst(rst),
    .push(wr),
    .pop(pix_pop),
    .din({eor, disp_in}),
    .dout(head),
    .full(pix_full),
    .empty(pix_empty)
  );

  sync_fifo #(.DW(RW), .DEPTH(4)) u_run (
    .clk(clk),
    .rst(rst),
    .push(wr && close),
    .pop(run_pop),
    .din({rfill, rlen}),
    .dout(run_head),
    .full(run_full),
    .empty(run_empty)
  );

  assign head_bad = |head[WIDTH+1:WIDTH];

  always_comb begin
    nstate = state;
    pix_pop = 1'b0;
    run_pop = 1'b0;
    cnt_ld = 1'b0;
    out_ld = 1'b0;
    out_d = head[WIDTH+1:0];
    if (clken) begin
      unique case (state)
        PASS: begin
          if (!pix_empty && !head_bad) begin
            pix_pop = 1'b1;
            out_ld = 1'b1;
          end else if (!pix_empty && !run_empty) begin
            cnt_ld = 1'b1;
            nstate = FILL;
          end
        end
        FILL: begin
          if (!pix_empty) begin
            pix_pop = 1'b1;
            out_ld = 1'b1;
            if (fill_en)
              out_d = {head[WIDTH+1:WIDTH],
                       run_head[RW-1:LW]};
            if (cnt == LW'(1)) begin
              run_pop = 1'b1;
              nstate = PASS;
            end
          end
        end
        default: nstate = PASS;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PASS;
      cnt <= '0;
      dq <= '0;
      vq <= 1'b0;
      rq <= 1'b0;
    end else if (clken) begin
      state <= nstate;
      if (cnt_ld) cnt <= run_head[LW-1:0];
      else if (out_ld && state == FILL) cnt <= cnt - 1'b1;
      vq <= out_ld;
      rq <= out_ld && head[PW-1];
      if (out_ld) dq <= out_d;
    end
  end

  assign disp_out = dq;
  assign valid_out = vq && clken;
  assign row_done = rq && clken;
endmodule

// File: tb/tb_lrc_hole_fill.sv
// Table-driven scoreboard bench for lrc_hole_fill.
module tb_lrc_hole_fill;
  localparam int MR = 64;
  localparam logic [17:0] OC = 18'h20000;
  localparam logic [17:0] MS = 18'h10000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clken = 1'b0;
  logic [10:0] img_width = 11'd8;
  logic fill_en = 1'b1;
  logic [15:0] invalid_val = '0;
  logic valid_in = 1'b0;
  logic [17:0] disp_in = '0;
  logic [17:0] disp_out;
  logic valid_out, row_done, overflow;

  lrc_hole_fill #(.WIDTH(16), .MAX_RUN(MR), .PIX_DEPTH(128)) dut (
    .clk(clk),
    .rst(rst),
    .clken(clken),
    .img_width(img_width),
    .fill_en(fill_en),
    .invalid_val(invalid_val),
    .valid_in(valid_in),
    .disp_in(disp_in),
    .disp_out(disp_out),
    .valid_out(valid_out),
    .row_done(row_done),
    .overflow(overflow)
  );

  typedef struct {
    logic [17:0] d;
    logic rd;
    int cyc;
    bit lat;
  } exp_t;

  typedef struct {
    logic [17:0] px [8];
    logic [17:0] ex [8];
    bit fe;
    logic [15:0] inv;
  } vec_t;

  exp_t q[$];
  vec_t tbl[8];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid_out) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_out got %h expected none", disp_out);
      end else begin
        e = q.pop_front();
        if (disp_out !== e.d || row_done !== e.rd) begin
          errors++;
          $display("FAIL pixel got %h rd=%b expected %h rd=%b",
                   disp_out, row_done, e.d, e.rd);
        end
        if (e.lat) begin
          checks++;
          if (cyc - e.cyc != 2) begin
            errors++;
            $display("FAIL latency got %0d expected 2", cyc - e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic push_px(input logic [17:0] v, input logic [17:0] e,
                         input logic last, input bit lat);
    @(negedge clk);
    valid_in = 1'b1;
    disp_in = v;
    q.push_back('{e, last, cyc, lat});
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
    disp_in = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0].px = '{18'd10, 18'd11, 18'd12, 18'd13,
                  18'd14, 18'd15, 18'd16, 18'd17};
    tbl[0].ex = tbl[0].px;
    tbl[0].fe = 1'b1; tbl[0].inv = 16'd0;
    tbl[1].px = '{18'd20, OC | 18'd99, OC | 18'd5, MS | 18'd77,
                  18'd30, 18'd31, 18'd32, 18'd33};
    tbl[1].ex = '{18'd20, OC | 18'd20, OC | 18'd20, MS | 18'd20,
                  18'd30, 18'd31, 18'd32, 18'd33};
    tbl[1].fe = 1'b1; tbl[1].inv = 16'd0;
    tbl[2].px = '{OC | 18'd1, OC | 18'd2, 18'd40, 18'd41,
                  18'd42, 18'd43, 18'd44, 18'd45};
    tbl[2].ex = '{OC | 18'd40, OC | 18'd40, 18'd40, 18'd41,
                  18'd42, 18'd43, 18'd44, 18'd45};
    tbl[2].fe = 1'b1; tbl[2].inv = 16'd0;
    tbl[3].px = '{18'd60, 18'd61, 18'd62, 18'd63,
                  18'd64, 18'd50, OC | 18'd3, OC | 18'd4};
    tbl[3].ex = '{18'd60, 18'd61, 18'd62, 18'd63,
                  18'd64, 18'd50, OC | 18'd50, OC | 18'd50};
    tbl[3].fe = 1'b1; tbl[3].inv = 16'd0;
    tbl[4].px = '{OC | 18'd5, OC | 18'd5, OC | 18'd5, OC | 18'd5,
                  MS | 18'd6, MS | 18'd6, MS | 18'd6, MS | 18'd6};
    tbl[4].ex = '{OC, OC, OC, OC, MS, MS, MS, MS};
    tbl[4].fe = 1'b1; tbl[4].inv = 16'd0;
    tbl[5].px = tbl[1].px;
    tbl[5].ex = tbl[1].px;
    tbl[5].fe = 1'b0; tbl[5].inv = 16'd0;
    tbl[6].px = tbl[4].px;
    tbl[6].ex = '{OC | 18'h1234, OC | 18'h1234, OC | 18'h1234,
                  OC | 18'h1234, MS | 18'h1234, MS | 18'h1234,
                  MS | 18'h1234, MS | 18'h1234};
    tbl[6].fe = 1'b1; tbl[6].inv = 16'h1234;
    tbl[7].px = '{18'd80, OC | 18'd1, 18'd25, MS | 18'd2,
                  MS | 18'd3, 18'd90, 18'd91, 18'd92};
    tbl[7].ex = '{18'd80, OC | 18'd25, 18'd25, MS | 18'd25,
                  MS | 18'd25, 18'd90, 18'd91, 18'd92};
    tbl[7].fe = 1'b1; tbl[7].inv = 16'd0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid_out", 32'(valid_out), 32'd0);
    chk("reset_row_done", 32'(row_done), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_disp_out", 32'(disp_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clken = 1'b1;

    for (int r = 0; r < 8; r++) begin
      fill_en = tbl[r].fe;
      invalid_val = tbl[r].inv;
      for (int i = 0; i < 8; i++)
        push_px(tbl[r].px[i], tbl[r].ex[i], i == 7, r == 0);
      idle();
      drain();
    end

    // clock enable stall holds a pending output
    fill_en = 1'b1;
    for (int i = 0; i < 7; i++)
      push_px(18'(i + 1), 18'(i + 1), 1'b0, 1'b0);
    push_px(18'd100, 18'd100, 1'b1, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    clken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("clken_low_valid", 32'(valid_out), 32'd0);
    end
    clken = 1'b1;
    drain();

    // run longer than MAX_RUN, closed by a right neighbour
    img_width = 11'(MR + 4);
    push_px(18'd7, 18'd7, 1'b0, 1'b0);
    for (int i = 0; i < MR + 2; i++) begin
      if (i[0]) push_px(MS | 18'(i), MS | 18'd7, 1'b0, 1'b0);
      else push_px(OC | 18'(i), OC | 18'd7, 1'b0, 1'b0);
    end
    push_px(18'd9, 18'd9, 1'b1, 1'b0);
    idle();
    drain();
    chk("maxrun_overflow", 32'(overflow), 32'd0);

    // reset with an open run, then a clean row
    img_width = 11'd8;
    push_px(18'd20, 18'd20, 1'b0, 1'b0);
    push_px(OC | 18'd1, OC | 18'd20, 1'b0, 1'b0);
    push_px(OC | 18'd2, OC | 18'd20, 1'b0, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    chk("pre_reset_pending", 32'(q.size()), 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst_valid_out", 32'(valid_out), 32'd0);
    chk("midrst_disp_out", 32'(disp_out), 32'd0);
    chk("midrst_row_done", 32'(row_done), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      push_px(tbl[1].px[i], tbl[1].ex[i], i == 7, 1'b0);
    idle();
    drain();
    chk("final_overflow", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
